// File: rtl/sync_ram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sync_ram_arbiter_pkg
// Shared definitions for the two-port RAM access controller:
//   - state_t   : controller FSM encoding (IDLE / ACCESS / RCAPT)
//   - REQ0/REQ1 : requester identifiers used for arbitration and data routing
// -----------------------------------------------------------------------------
package sync_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RCAPT  = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Purely combinational two-way round-robin pick. The caller owns and registers
// the last-granted requester.
// Ports:
//   req0, req1 : request lines
//   last_gnt   : requester granted most recently (REQ0 / REQ1)
//   winner     : selected requester (meaningful only when any_req is high)
//   any_req    : at least one request present
// -----------------------------------------------------------------------------
module rr_arb2
  import sync_ram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic winner,
  output logic any_req
);

  always_comb begin
    any_req = req0 | req1;
    // On a tie the requester that did not win last time goes first.
    if (req0 && req1) begin
      winner = ~last_gnt;
    end else if (req1) begin
      winner = REQ1;
    end else begin
      winner = REQ0;
    end
  end

endmodule

// File: rtl/sync_ram_arbiter.sv
// -----------------------------------------------------------------------------
// sync_ram_arbiter
// Round-robin access controller placing two requesters onto one single-port
// synchronous RAM. Commands are accepted in IDLE, driven onto the registered
// RAM pins for one ACCESS cycle, and reads come back through RCAPT with a
// one-cycle rvalid pulse to the owning requester.
//
// Handshake: a requester holds req and its command fields (we/addr/wdata)
// stable until it observes gnt=1 (a one-cycle pulse during ACCESS). Requests
// seen in ACCESS or RCAPT are ignored; a req still high in IDLE after its gnt
// is taken as a new command. rvalidN is a one-cycle pulse; rdataN holds its
// value until the next read for that port completes.
//
// Optional build macro RAMARB_ADDR_CHECK_EN: commands with addr >= DPTH are
// still granted, but the RAM strobes stay low, err pulses in the ACCESS cycle,
// out-of-range writes are dropped and out-of-range reads return zero.
// Without the macro err is constant 0 and any address goes to the RAM.
//
// Ports:
//   Clk, Rst_n                 : clock, asynchronous active-low reset
//   req/we/addr/wdata 0,1      : requester command inputs
//   gnt0, gnt1                 : accept pulses
//   rvalid0/1, rdata0/1        : read return
//   ramCS/WE/RD/Addr/DataIn    : registered RAM pins
//   ramDataOut                 : RAM read data (valid in RCAPT)
//   busy                       : controller not in IDLE
//   err                        : out-of-range address pulse
//   fsm_state                  : current controller state (observability)
// -----------------------------------------------------------------------------
module sync_ram_arbiter
  import sync_ram_arbiter_pkg::*;
#(
  parameter int ADR  = 8,
  parameter int DAT  = 8,
  parameter int DPTH = 8
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic           req0,
  input  logic           req1,
  input  logic           we0,
  input  logic           we1,
  input  logic [ADR-1:0] addr0,
  input  logic [ADR-1:0] addr1,
  input  logic [DAT-1:0] wdata0,
  input  logic [DAT-1:0] wdata1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           rvalid0,
  output logic           rvalid1,
  output logic [DAT-1:0] rdata0,
  output logic [DAT-1:0] rdata1,
  output logic           ramCS,
  output logic           ramWE,
  output logic           ramRD,
  output logic [ADR-1:0] ramAddr,
  output logic [DAT-1:0] ramDataIn,
  input  logic [DAT-1:0] ramDataOut,
  output logic           busy,
  output logic           err,
  output logic [1:0]     fsm_state
);

`ifdef RAMARB_ADDR_CHECK_EN
  localparam logic ADDR_CHECK = 1'b1;
`else
  localparam logic ADDR_CHECK = 1'b0;
`endif

  // One extra bit so DPTH = 2**ADR still compares correctly.
  localparam logic [ADR:0] DEPTH_L = (ADR+1)'(DPTH);

  state_t state, state_d;
  logic   last_gnt, last_gnt_d;
  logic   owner, owner_d;      // requester whose command is in flight
  logic   is_rd, is_rd_d;      // in-flight command is a read
  logic   oor, oor_d;          // in-flight command is out of range

  logic           gnt0_d, gnt1_d, rvalid0_d, rvalid1_d;
  logic           cs_d, we_d, rd_d, err_d;
  logic [ADR-1:0] addr_d;
  logic [DAT-1:0] din_d, rdata0_d, rdata1_d;

  logic           winner, any_req;
  logic           sel_we, sel_oor;
  logic [ADR-1:0] sel_addr;
  logic [DAT-1:0] sel_wdata;

  rr_arb2 u_arb (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt),
    .winner   (winner),
    .any_req  (any_req)
  );

  assign sel_we    = (winner == REQ1) ? we1    : we0;
  assign sel_addr  = (winner == REQ1) ? addr1  : addr0;
  assign sel_wdata = (winner == REQ1) ? wdata1 : wdata0;
  assign sel_oor   = ADDR_CHECK & ({1'b0, sel_addr} >= DEPTH_L);

  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

  always_comb begin
    state_d    = state;
    last_gnt_d = last_gnt;
    owner_d    = owner;
    is_rd_d    = is_rd;
    oor_d      = oor;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    cs_d       = 1'b0;
    we_d       = 1'b0;
    rd_d       = 1'b0;
    err_d      = 1'b0;
    addr_d     = ramAddr;
    din_d      = ramDataIn;
    rdata0_d   = rdata0;
    rdata1_d   = rdata1;

    case (state)
      ST_IDLE: begin
        if (any_req) begin
          last_gnt_d = winner;
          owner_d    = winner;
          is_rd_d    = ~sel_we;
          oor_d      = sel_oor;
          gnt0_d     = (winner == REQ0);
          gnt1_d     = (winner == REQ1);
          // Out-of-range commands keep every strobe low; err marks them.
          cs_d       = ~sel_oor;
          we_d       = sel_we & ~sel_oor;
          rd_d       = ~sel_we & ~sel_oor;
          err_d      = sel_oor;
          addr_d     = sel_addr;
          din_d      = sel_wdata;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = is_rd ? ST_RCAPT : ST_IDLE;
      end
      ST_RCAPT: begin
        if (owner == REQ1) begin
          rvalid1_d = 1'b1;
          rdata1_d  = oor ? '0 : ramDataOut;
        end else begin
          rvalid0_d = 1'b1;
          rdata0_d  = oor ? '0 : ramDataOut;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= ST_IDLE;
      last_gnt  <= REQ1;
      owner     <= REQ0;
      is_rd     <= 1'b0;
      oor       <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      ramCS     <= 1'b0;
      ramWE     <= 1'b0;
      ramRD     <= 1'b0;
      err       <= 1'b0;
      ramAddr   <= '0;
      ramDataIn <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      state     <= state_d;
      last_gnt  <= last_gnt_d;
      owner     <= owner_d;
      is_rd     <= is_rd_d;
      oor       <= oor_d;
      gnt0      <= gnt0_d;
      gnt1      <= gnt1_d;
      rvalid0   <= rvalid0_d;
      rvalid1   <= rvalid1_d;
      ramCS     <= cs_d;
      ramWE     <= we_d;
      ramRD     <= rd_d;
      err       <= err_d;
      ramAddr   <= addr_d;
      ramDataIn <= din_d;
      rdata0    <= rdata0_d;
      rdata1    <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sync_ram_arbiter
// Bench for sync_ram_arbiter with a behavioural single-port RAM attached.
// Reference model: per-port command queues, a shadow memory, a round-robin
// tie-break flag and a "controller free at cycle" counter derived from the
// write (2-cycle) and read (3-cycle) occupancy; read returns are kept in an
// expected queue keyed by the cycle they must appear in.
// -----------------------------------------------------------------------------
module tb_sync_ram_arbiter;

  localparam int ADR  = 8;
  localparam int DAT  = 8;
  localparam int DPTH = 8;

`ifdef RAMARB_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  typedef struct packed {
    logic           we;
    logic [ADR-1:0] addr;
    logic [DAT-1:0] data;
  } cmd_t;

  // ---------------- clock / reset ----------------
  logic Clk   = 1'b0;
  logic Rst_n = 1'b1;
  always #5 Clk = ~Clk;

  logic           req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [ADR-1:0] addr0 = '0, addr1 = '0;
  logic [DAT-1:0] wdata0 = '0, wdata1 = '0;
  logic           gnt0, gnt1, rvalid0, rvalid1;
  logic [DAT-1:0] rdata0, rdata1;
  logic           ramCS, ramWE, ramRD;
  logic [ADR-1:0] ramAddr;
  logic [DAT-1:0] ramDataIn;
  logic [DAT-1:0] ramDataOut;
  logic           busy, err;
  logic [1:0]     fsm_state;

  sync_ram_arbiter #(.ADR(ADR), .DAT(DAT), .DPTH(DPTH)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .req0       (req0),
    .req1       (req1),
    .we0        (we0),
    .we1        (we1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .rvalid0    (rvalid0),
    .rvalid1    (rvalid1),
    .rdata0     (rdata0),
    .rdata1     (rdata1),
    .ramCS      (ramCS),
    .ramWE      (ramWE),
    .ramRD      (ramRD),
    .ramAddr    (ramAddr),
    .ramDataIn  (ramDataIn),
    .ramDataOut (ramDataOut),
    .busy       (busy),
    .err        (err),
    .fsm_state  (fsm_state)
  );

  // Behavioural single-port synchronous RAM (full address space).
  logic [DAT-1:0] ram_mem [0:255];
  always @(posedge Clk) begin
    if (ramCS && ramWE) ram_mem[ramAddr] <= ramDataIn;
    if (ramCS && ramRD) ramDataOut <= ram_mem[ramAddr];
  end

  // ---------------- reference model state ----------------
  logic [DAT-1:0] model_mem [0:255];
  logic [DAT-1:0] held_rdata [0:1];
  bit             last_gnt;
  int             t;        // negedge index
  int             free_at;  // first cycle a new gnt may be visible
  cmd_t           cq0[$];
  cmd_t           cq1[$];
  logic [DAT-1:0] exp_q[$];
  int             exp_cyc_q[$];
  bit             exp_port_q[$];

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  function automatic cmd_t mk_cmd(input logic we, input int addr, input int data);
    cmd_t c;
    c.we   = we;
    c.addr = ADR'(addr);
    c.data = DAT'(data);
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    return mk_cmd(1'($urandom_range(0, 1)), int'($urandom_range(0, 9)), int'($urandom_range(0, 255)));
  endfunction

  // ---------------- driver ----------------
  task automatic present();
    if (cq0.size() > 0) begin
      req0 = 1'b1; we0 = cq0[0].we; addr0 = cq0[0].addr; wdata0 = cq0[0].data;
    end else begin
      req0 = 1'b0;
    end
    if (cq1.size() > 0) begin
      req1 = 1'b1; we1 = cq1[0].we; addr1 = cq1[0].addr; wdata1 = cq1[0].data;
    end else begin
      req1 = 1'b0;
    end
  endtask

  // Compare one cycle of DUT outputs against the model; called at a negedge,
  // before inputs for the next edge are changed.
  task automatic step();
    bit             g0, g1, w, oor, rv0, rv1, p;
    cmd_t           c;
    logic [DAT-1:0] d;
    g0 = 1'b0; g1 = 1'b0; rv0 = 1'b0; rv1 = 1'b0;
    if (t >= free_at && (req0 || req1)) begin
      w = (req0 && req1) ? ~last_gnt : bit'(req1);
      last_gnt = w;
      if (w) begin c = cq1.pop_front(); g1 = 1'b1; end
      else   begin c = cq0.pop_front(); g0 = 1'b1; end
      oor = ADDR_CHECK && (int'(c.addr) >= DPTH);
      check("ram_cs",  32'(ramCS), 32'(!oor));
      check("ram_we",  32'(ramWE), 32'(c.we && !oor));
      check("ram_rd",  32'(ramRD), 32'(!c.we && !oor));
      check("err",     32'(err),   32'(oor));
      if (!oor) check("ram_addr", 32'(ramAddr), 32'(c.addr));
      if (c.we) begin
        if (!oor) begin
          check("ram_din", 32'(ramDataIn), 32'(c.data));
          model_mem[c.addr] = c.data;
        end
        free_at = t + 2;
      end else begin
        d = oor ? DAT'(0) : model_mem[c.addr];
        exp_q.push_back(d);
        exp_cyc_q.push_back(t + 2);
        exp_port_q.push_back(w);
        free_at = t + 3;
      end
    end else begin
      check("ram_cs_idle", 32'(ramCS), 32'(0));
      check("ram_we_idle", 32'(ramWE), 32'(0));
      check("ram_rd_idle", 32'(ramRD), 32'(0));
      check("err_idle",    32'(err),   32'(0));
    end
    check("gnt0", 32'(gnt0), 32'(g0));
    check("gnt1", 32'(gnt1), 32'(g1));
    check("busy", 32'(busy), 32'(t <= free_at - 2));
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == t) begin
      void'(exp_cyc_q.pop_front());
      p = exp_port_q.pop_front();
      d = exp_q.pop_front();
      held_rdata[p] = d;
      if (p) rv1 = 1'b1; else rv0 = 1'b1;
    end
    check("rvalid0", 32'(rvalid0), 32'(rv0));
    check("rvalid1", 32'(rvalid1), 32'(rv1));
    check("rdata0",  32'(rdata0),  32'(held_rdata[0]));
    check("rdata1",  32'(rdata1),  32'(held_rdata[1]));
  endtask

  // Drain both command queues and all pending read returns, then idle a little.
  task automatic run(input int budget);
    int n;
    n = 0;
    present();
    while ((cq0.size() > 0 || cq1.size() > 0 || exp_q.size() > 0) && n < budget) begin
      @(negedge Clk);
      t++; n++;
      step();
      present();
    end
    check("run_in_budget", 32'(n < budget), 32'(1));
    repeat (3) begin
      @(negedge Clk);
      t++;
      step();
    end
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    #1;
    check("rst_gnt0",    32'(gnt0),      32'(0));
    check("rst_gnt1",    32'(gnt1),      32'(0));
    check("rst_rvalid0", 32'(rvalid0),   32'(0));
    check("rst_rvalid1", 32'(rvalid1),   32'(0));
    check("rst_cs",      32'(ramCS),     32'(0));
    check("rst_we",      32'(ramWE),     32'(0));
    check("rst_rd",      32'(ramRD),     32'(0));
    check("rst_busy",    32'(busy),      32'(0));
    check("rst_err",     32'(err),       32'(0));
    check("rst_addr",    32'(ramAddr),   32'(0));
    check("rst_din",     32'(ramDataIn), 32'(0));
    check("rst_rdata0",  32'(rdata0),    32'(0));
    check("rst_rdata1",  32'(rdata1),    32'(0));
    check("rst_state",   32'(fsm_state), 32'(0));
    repeat (2) begin
      @(negedge Clk);
      t++;
    end
    Rst_n = 1'b1;
    last_gnt = 1'b1;
    free_at  = t;
    held_rdata[0] = '0;
    held_rdata[1] = '0;
    cq0.delete();
    cq1.delete();
    exp_q.delete();
    exp_cyc_q.delete();
    exp_port_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i]   = '0;
      model_mem[i] = '0;
    end
    t = 0;
    free_at = 0;
    last_gnt = 1'b1;
    #2;
    do_reset();

    // Write then read back on port 0.
    cq0.push_back(mk_cmd(1'b1, 3, 8'hA5));
    run(20);
    check("ram3_written", 32'(ram_mem[3]), 32'(8'hA5));
    cq0.push_back(mk_cmd(1'b0, 3, 0));
    run(20);
    check("rdata0_a5", 32'(rdata0), 32'(8'hA5));

    // Simultaneous writes straight out of reset: port 0 goes first.
    @(negedge Clk); t++;
    do_reset();
    cq0.push_back(mk_cmd(1'b1, 1, 8'h11));
    cq1.push_back(mk_cmd(1'b1, 2, 8'h22));
    run(20);
    check("ram1_written", 32'(ram_mem[1]), 32'(8'h11));
    check("ram2_written", 32'(ram_mem[2]), 32'(8'h22));

    // Fairness: both requesters busy for three commands each.
    for (int k = 0; k < 3; k++) begin
      cq0.push_back(mk_cmd(1'b1, k, 16 + k));
      cq1.push_back(mk_cmd(1'b1, 4 + k, 32 + k));
    end
    run(40);

    // Read routing to port 1 leaves port 0 untouched.
    cq0.push_back(mk_cmd(1'b1, 5, 8'h3C));
    run(20);
    cq1.push_back(mk_cmd(1'b0, 5, 0));
    run(20);
    check("rdata1_3c", 32'(rdata1), 32'(8'h3C));

    // Boundary addresses: last valid word and first out-of-range word.
    cq0.push_back(mk_cmd(1'b1, DPTH - 1, 8'h77));
    cq1.push_back(mk_cmd(1'b0, DPTH, 0));
    run(20);
    cq0.push_back(mk_cmd(1'b1, DPTH, 8'h99));
    cq1.push_back(mk_cmd(1'b0, DPTH - 1, 0));
    run(20);
    cq0.push_back(mk_cmd(1'b0, DPTH, 0));
    run(20);

    // Randomized mixes of reads and writes on both ports.
    for (int i = 0; i < 40; i++) begin
      int n0, n1;
      n0 = int'($urandom_range(0, 3));
      n1 = int'($urandom_range(0, 3));
      for (int k = 0; k < n0; k++) cq0.push_back(rand_cmd());
      for (int k = 0; k < n1; k++) cq1.push_back(rand_cmd());
      run(100);
    end

    // Reset during the ACCESS cycle of a read aborts it.
    cq0.push_back(mk_cmd(1'b0, 3, 0));
    present();
    @(negedge Clk); t++;
    step();
    check("abort_read_granted", 32'(gnt0 && ramRD), 32'(1));
    do_reset();
    repeat (5) begin
      @(negedge Clk); t++;
      step();
    end
    check("abort_idle_state", 32'(fsm_state), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
